// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
interface pipelined_cla_addsub_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             as;
  logic [1:0]       sat;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  // Producer/consumer side
  modport master (
    output A, B, as, sat, in_valid, out_ready,
    input  in_ready, sum, cout, ovf, out_valid
  );

  // Adder side
  modport slave (
    input  A, B, as, sat, in_valid, out_ready,
    output in_ready, sum, cout, ovf, out_valid
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined two-level carry-lookahead adder/subtractor with saturation modes,
// signed overflow flag and a stall-all valid/ready pipeline.
module pipelined_cla_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  pipelined_cla_addsub_if.slave bus
);
  localparam int unsigned MSB  = WIDTH - 1;
  localparam int unsigned NGRP = WIDTH / BLOCK;
  // Result-carrying stages; with a single stage the result is formed from the ports.
  localparam int unsigned NRES = (STAGES > 1) ? STAGES - 1 : 1;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             as;
    logic [1:0]       sat;
  } op_t;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  op_t              in_op;
  op_t              op_src;
  op_t              op_d;
  op_t              op_q;
  res_t             res_new;
  res_t             res_d [NRES];
  res_t             res_q [NRES];
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] add_raw;
  logic [WIDTH-1:0] sat_sum;
  logic             add_cout;
  logic             add_ovf;
  logic             adv;

  // Two-level CLA: bit P/G -> group P/G -> group carries -> bit carries. Returns {cout, raw}.
  function automatic logic [WIDTH:0] cla_add(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             cin
  );
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;
    logic [NGRP-1:0]  gp;
    logic [NGRP-1:0]  gg;
    logic [NGRP:0]    gc;
    p = a ^ b;
    g = a & b;
    for (int unsigned k = 0; k < NGRP; k++) begin
      gp[k] = &p[k*BLOCK +: BLOCK];
      gg[k] = 1'b0;
      for (int unsigned j = 0; j < BLOCK; j++) begin
        gg[k] = g[k*BLOCK+j] | (p[k*BLOCK+j] & gg[k]);
      end
    end
    gc[0] = cin;
    for (int unsigned k = 0; k < NGRP; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int unsigned k = 0; k < NGRP; k++) begin
      c[k*BLOCK] = gc[k];
      for (int unsigned j = 1; j < BLOCK; j++) begin
        c[k*BLOCK+j] = g[k*BLOCK+j-1] | (p[k*BLOCK+j-1] & c[k*BLOCK+j-1]);
      end
    end
    return {gc[NGRP], p ^ c};
  endfunction

  // Gather the input beat from the bus
  always_comb begin
    in_op.vld = bus.in_valid;
    in_op.a   = bus.A;
    in_op.b   = bus.B;
    in_op.as  = bus.as;
    in_op.sat = bus.sat;
  end

  // Add/subtract, flag and saturate the operands feeding the first result stage
  always_comb begin
    op_src  = (STAGES == 1) ? in_op : op_q;
    b_eff   = op_src.b ^ {WIDTH{op_src.as}};
    {add_cout, add_raw} = cla_add(op_src.a, b_eff, op_src.as);
    add_ovf = (op_src.a[MSB] == b_eff[MSB]) && (add_raw[MSB] != op_src.a[MSB]);
    sat_sum = add_raw;
    case (op_src.sat)
      2'b01: begin
        if (!op_src.as && add_cout) begin
          sat_sum = {WIDTH{1'b1}};
        end else if (op_src.as && !add_cout) begin
          sat_sum = {WIDTH{1'b0}};
        end
      end
      2'b10: begin
        if (add_ovf) begin
          sat_sum = op_src.a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
      default: sat_sum = add_raw;
    endcase
    res_new.vld  = op_src.vld;
    res_new.sum  = sat_sum;
    res_new.cout = add_cout;
    res_new.ovf  = add_ovf;
  end

  // Whole pipeline advances together unless a valid result is being refused
  always_comb begin
    adv   = !(res_q[NRES-1].vld && !bus.out_ready);
    op_d  = op_q;
    res_d = res_q;
    if (adv) begin
      op_d     = in_op;
      res_d[0] = res_new;
      for (int unsigned i = 1; i < NRES; i++) begin
        res_d[i] = res_q[i-1];
      end
    end
  end

  // Stage registers; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      for (int unsigned i = 0; i < NRES; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      op_q <= op_d;
      for (int unsigned i = 0; i < NRES; i++) begin
        res_q[i] <= res_d[i];
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = res_q[NRES-1].vld;
  assign bus.sum       = res_q[NRES-1].sum;
  assign bus.cout      = res_q[NRES-1].cout;
  assign bus.ovf       = res_q[NRES-1].ovf;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub (WIDTH 16, BLOCK 4, STAGES 2).
module tb_pipelined_cla_addsub;
  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [1:0]   m;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  pipelined_cla_addsub_if #(.WIDTH(W)) bus ();

  pipelined_cla_addsub #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, then clamp per mode
  function automatic exp_t model(input beat_t bt);
    exp_t e;
    int ua = int'(bt.a);
    int ub = int'(bt.b);
    int sa = int'($signed(bt.a));
    int sb = int'($signed(bt.b));
    int ur = bt.s ? ua - ub : ua + ub;
    int sr = bt.s ? sa - sb : sa + sb;
    e.cout = bt.s ? (ua >= ub) : (ur > 65535);
    e.ovf  = (sr > 32767) || (sr < -32768);
    e.sum  = 16'(ur);
    if (bt.m == 2'b01) begin
      if (ur > 65535) e.sum = 16'hFFFF;
      else if (ur < 0) e.sum = 16'h0000;
    end else if (bt.m == 2'b10) begin
      if (sr > 32767) e.sum = 16'h7FFF;
      else if (sr < -32768) e.sum = 16'h8000;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] corner [5];
    corner = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  function automatic beat_t rand_beat();
    beat_t bt;
    bt.a = rand_op();
    bt.b = rand_op();
    bt.s = 1'($urandom_range(0, 1));
    bt.m = 2'($urandom_range(0, 3));
    return bt;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.sum  = bus.sum;
    o.cout = bus.cout;
    o.ovf  = bus.ovf;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input beat_t bt, input logic v);
    bus.A        = bt.a;
    bus.B        = bt.b;
    bus.as       = bt.s;
    bus.sat      = bt.m;
    bus.in_valid = v;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b0;
    drive('0, 1'b0);
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.sum !== 16'h0) begin errors++; $display("FAIL reset_sum got %h want 0000", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    step();
  endtask

  task automatic test_latency();
    exp_t want;
    want = '{sum: 16'd19, cout: 1'b0, ovf: 1'b0};
    bus.out_ready = 1'b1;
    drive('{a: 16'd16, b: 16'd3, s: 1'b0, m: 2'b00}, 1'b1);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL lat_accept in_ready got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_early out_valid got %b want 0", bus.out_valid); end
    step();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_due out_valid got %b want 1", bus.out_valid); end
    checks++; if (observed() !== want) begin errors++; $display("FAIL lat_result got %h want %h", observed(), want); end
    step();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_after out_valid got %b want 0", bus.out_valid); end
    step();
  endtask

  task automatic test_directed();
    beat_t vb [11];
    exp_t  ve [11];
    logic  got;
    vb[0]  = '{a: 16'h8000, b: 16'h8000, s: 1'b1, m: 2'b00}; ve[0]  = '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0};
    vb[1]  = '{a: 16'd1,    b: 16'd100,  s: 1'b1, m: 2'b01}; ve[1]  = '{sum: 16'h0000, cout: 1'b0, ovf: 1'b0};
    vb[2]  = '{a: 16'd60000, b: 16'd33000, s: 1'b0, m: 2'b00}; ve[2] = '{sum: 16'd27464, cout: 1'b1, ovf: 1'b1};
    vb[3]  = '{a: 16'd60000, b: 16'd33000, s: 1'b0, m: 2'b01}; ve[3] = '{sum: 16'd65535, cout: 1'b1, ovf: 1'b1};
    vb[4]  = '{a: 16'h7FFF, b: 16'h0001, s: 1'b0, m: 2'b10}; ve[4]  = '{sum: 16'h7FFF, cout: 1'b0, ovf: 1'b1};
    vb[5]  = '{a: 16'h8000, b: 16'h0001, s: 1'b1, m: 2'b10}; ve[5]  = '{sum: 16'h8000, cout: 1'b1, ovf: 1'b1};
    vb[6]  = '{a: 16'h7FFF, b: 16'h0001, s: 1'b0, m: 2'b00}; ve[6]  = '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1};
    vb[7]  = '{a: 16'h8000, b: 16'h0001, s: 1'b1, m: 2'b00}; ve[7]  = '{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1};
    vb[8]  = '{a: 16'hFFFF, b: 16'h0001, s: 1'b0, m: 2'b00}; ve[8]  = '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0};
    vb[9]  = '{a: 16'h0000, b: 16'h0001, s: 1'b1, m: 2'b00}; ve[9]  = '{sum: 16'hFFFF, cout: 1'b0, ovf: 1'b0};
    vb[10] = '{a: 16'h7FFF, b: 16'h0001, s: 1'b0, m: 2'b11}; ve[10] = '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(vb[i], 1'b1);
      step();
      bus.in_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (bus.out_valid === 1'b1) got = 1'b1;
        else step();
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL dir%0d_timeout out_valid got 0 want 1", i);
      end else if (observed() !== ve[i]) begin
        errors++; $display("FAIL dir%0d_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                           i, bus.sum, bus.cout, bus.ovf, ve[i].sum, ve[i].cout, ve[i].ovf);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    beat_t bts [8];
    exp_t  e;
    int    sent = 0, rcvd = 0, first = -1, last = -1;
    for (int i = 0; i < 8; i++) bts[i] = rand_beat();
    sb_q.delete();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
      if (sent < 8) drive(bts[sent], 1'b1);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got sum=%h want no result", bus.sum);
        end else begin
          e = sb_q.pop_front();
          if (observed() !== e) begin errors++; $display("FAIL b2b_result got %h want %h", observed(), e); end
        end
        if (first < 0) first = cyc;
        last = cyc;
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) begin sb_q.push_back(model(bts[sent])); sent++; end
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (rcvd != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", rcvd); end
    checks++; if (last - first != 7) begin errors++; $display("FAIL b2b_rate got span %0d want 7", last - first); end
  endtask

  task automatic test_backpressure();
    beat_t bts [4];
    exp_t  e;
    int    sent = 0, rcvd = 0;
    for (int i = 0; i < 4; i++) bts[i] = rand_beat();
    sb_q.delete();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(bts[sent], 1'b1);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin sb_q.push_back(model(bts[sent])); sent++; end
      step();
    end
    checks++; if (sent != 2) begin errors++; $display("FAIL bp_fill got %0d accepted want 2", sent); end
    for (int c = 0; c < 3; c++) begin
      drive(bts[sent], 1'b1);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall%0d out_valid got %b want 1", c, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d in_ready got %b want 0", c, bus.in_ready); end
      checks++; if (sb_q.size() == 0 || bus.sum !== sb_q[0].sum) begin
        errors++; $display("FAIL bp_stall%0d sum got %h want %h", c, bus.sum, (sb_q.size() == 0) ? 16'h0 : sb_q[0].sum);
      end
      step();
    end
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && rcvd < 4; cyc++) begin
      if (sent < 4) drive(bts[sent], 1'b1);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL bp_extra got sum=%h want no result", bus.sum);
        end else begin
          e = sb_q.pop_front();
          if (observed() !== e) begin errors++; $display("FAIL bp_result%0d got %h want %h", rcvd, observed(), e); end
        end
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) begin sb_q.push_back(model(bts[sent])); sent++; end
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (rcvd != 4 || sb_q.size() != 0) begin
      errors++; $display("FAIL bp_drain got %0d results (%0d left) want 4 (0 left)", rcvd, sb_q.size());
    end
  endtask

  task automatic test_reset_midstall();
    beat_t bt;
    exp_t  want;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(rand_beat(), 1'b1);
      step();
    end
    reset = 1'b1;
    bus.in_valid = 1'b0;
    step();
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.sum !== 16'h0) begin errors++; $display("FAIL rst_stall sum got %h want 0000", bus.sum); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_stall in_ready got %b want 1", bus.in_ready); end
    step();
    bt = '{a: 16'h1234, b: 16'h0101, s: 1'b0, m: 2'b00};
    want = '{sum: 16'h1335, cout: 1'b0, ovf: 1'b0};
    bus.out_ready = 1'b1;
    drive(bt, 1'b1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_new early out_valid got %b want 0", bus.out_valid); end
    step();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_new out_valid got %b want 1", bus.out_valid); end
    checks++; if (observed() !== want) begin errors++; $display("FAIL rst_new result got %h want %h", observed(), want); end
    step();
  endtask

  task automatic test_random();
    localparam int N = 10000;
    beat_t cur;
    exp_t  e;
    logic  pend = 1'b0;
    int    sent = 0, rcvd = 0;
    sb_q.delete();
    cur = '0;
    for (int cyc = 0; cyc < 60000 && rcvd < N; cyc++) begin
      if (!pend && sent < N && $urandom_range(0, 3) != 0) begin cur = rand_beat(); pend = 1'b1; end
      drive(cur, pend);
      bus.out_ready = ($urandom_range(0, 3) != 0) || (sent >= N);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
        errors++; $display("FAIL rnd_in_ready got %b want %b", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra got sum=%h want no result", bus.sum);
        end else begin
          e = sb_q.pop_front();
          if (observed() !== e) begin errors++; $display("FAIL rnd_result%0d got %h want %h", rcvd, observed(), e); end
        end
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) begin sb_q.push_back(model(cur)); sent++; pend = 1'b0; end
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (rcvd != N || sb_q.size() != 0) begin
      errors++; $display("FAIL rnd_count got %0d results (%0d left) want %0d", rcvd, sb_q.size(), N);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
